// File: rtl/hwpe_ctrl_nested_counter.sv
// Nested-loop index/address generator: snapshots loop ranges, strides and base on start,
// then emits one (index tuple, address) beat per accepted handshake until the last one.
module hwpe_ctrl_nested_counter #(
    parameter int unsigned NB_LOOPS   = 3,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             start_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]    range_i,
    input  logic [NB_LOOPS*ADDR_WIDTH-1:0]   stride_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    input  logic                             ready_i,
    output logic                             valid_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]    idx_o,
    output logic [ADDR_WIDTH-1:0]            addr_o,
    output logic                             last_o,
    output logic                             busy_o,
    output logic                             done_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // RUN   | presenting beats on the valid/ready stream
    // DONE  | one-cycle done pulse after the last beat is accepted
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned IW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_e                                 state_q, state_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]     range_q, range_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]     idx_q, idx_d;
    logic [NB_LOOPS-1:0][ADDR_WIDTH-1:0]    stride_q, stride_d;
    logic [NB_LOOPS-1:0][ADDR_WIDTH-1:0]    off_q, off_d;

    logic [NB_LOOPS-1:0]                    at_max;
    logic                                   all_max;
    logic [IW-1:0]                          adv_k;
    logic                                   adv_found;
    logic [ADDR_WIDTH-1:0]                  step_addr;

    // A range of 0 behaves as a single-iteration loop, so index 0 is its maximum.
    always_comb begin
        at_max = '0;
        for (int k = 0; k < NB_LOOPS; k++) begin
            if (range_q[k] == '0) at_max[k] = (idx_q[k] == '0);
            else                  at_max[k] = (idx_q[k] == range_q[k] - ONE);
        end
    end

    assign all_max = &at_max;

    always_comb begin
        adv_k     = '0;
        adv_found = 1'b0;
        for (int k = 0; k < NB_LOOPS; k++) begin
            if (!adv_found && !at_max[k]) begin
                adv_found = 1'b1;
                adv_k     = IW'(k);
            end
        end
        step_addr = off_q[adv_k] + stride_q[adv_k];
    end

    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        stride_d = stride_q;
        idx_d    = idx_q;
        off_d    = off_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    range_d  = range_i;
                    stride_d = stride_i;
                    idx_d    = '0;
                    for (int k = 0; k < NB_LOOPS; k++) off_d[k] = base_addr_i;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (ready_i) begin
                    if (all_max) begin
                        state_d = DONE;
                    end else begin
                        for (int j = 0; j < NB_LOOPS; j++) begin
                            if (IW'(j) < adv_k) begin
                                idx_d[j] = '0;
                                off_d[j] = step_addr;
                            end else if (IW'(j) == adv_k) begin
                                idx_d[j] = idx_q[j] + ONE;
                                off_d[j] = step_addr;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= IDLE;
            range_q  <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            range_q  <= range_d;
            stride_q <= stride_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
        end
    end

    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    // Cleared registers look like "all indices at max", so only flag last while running.
    assign last_o  = (state_q == RUN) && all_max;
    assign idx_o   = idx_q;
    assign addr_o  = off_q[0];

endmodule

// File: tb/tb_hwpe_ctrl_nested_counter.sv
// Self-checking bench for hwpe_ctrl_nested_counter: beats are compared against a mixed-radix
// model where addr = base + sum(idx[k]*stride[k]) mod 2^32.
module tb_hwpe_ctrl_nested_counter;
    localparam int NL = 3;
    localparam int CW = 12;
    localparam int AW = 32;

    logic                clk = 1'b0;
    logic                rst, clear, start, ready;
    logic [NL*CW-1:0]    range_v;
    logic [NL*AW-1:0]    stride_v;
    logic [AW-1:0]       base_addr;
    logic                valid_o, last_o, busy_o, done_o;
    logic [NL*CW-1:0]    idx_o;
    logic [AW-1:0]       addr_o;

    int checks = 0;
    int failures = 0;

    logic [NL*CW-1:0] q_idx[$];
    logic [AW-1:0]    q_addr[$];
    logic             q_last[$];
    logic [NL*CW-1:0] e_idx[$];
    logic [AW-1:0]    e_addr[$];
    logic             e_last[$];
    int n_done, done_cyc, last_cyc, first_cyc, stab_err, busy_err, post_valid;
    bit timeout;

    hwpe_ctrl_nested_counter #(.NB_LOOPS(NL), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .range_i(range_v), .stride_i(stride_v), .base_addr_i(base_addr),
        .ready_i(ready), .valid_o(valid_o), .idx_o(idx_o), .addr_o(addr_o),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic void build_model(input logic [NL*CW-1:0] r, input logic [NL*AW-1:0] s,
                                        input logic [AW-1:0] b);
        int eff[NL];
        int total = 1;
        e_idx.delete(); e_addr.delete(); e_last.delete();
        for (int k = 0; k < NL; k++) begin
            eff[k] = (r[k*CW +: CW] == '0) ? 1 : int'(r[k*CW +: CW]);
            total *= eff[k];
        end
        for (int n = 0; n < total; n++) begin
            int rem = n;
            logic [AW-1:0] a = b;
            logic [NL*CW-1:0] t = '0;
            for (int k = 0; k < NL; k++) begin
                int i = rem % eff[k];
                rem = rem / eff[k];
                t[k*CW +: CW] = CW'(i);
                a = a + AW'(i) * s[k*AW +: AW];
            end
            e_idx.push_back(t);
            e_addr.push_back(a);
            e_last.push_back(n == total - 1);
        end
    endfunction

    task automatic start_job(input logic [NL*CW-1:0] r, input logic [NL*AW-1:0] s,
                             input logic [AW-1:0] b);
        @(negedge clk);
        range_v = r; stride_v = s; base_addr = b; start = 1'b1;
    endtask

    // Runs the stream until a few cycles past done_o, recording every accepted beat.
    task automatic collect(input int mode, input int start_at, input bit start_on_done,
                           input int max_cyc);
        logic [NL*CW-1:0] h_idx = '0;
        logic [AW-1:0]    h_addr = '0;
        logic             h_last = 1'b0;
        bit stalled = 1'b0;
        int cyc = 0;
        q_idx.delete(); q_addr.delete(); q_last.delete();
        n_done = 0; done_cyc = -1; last_cyc = -1; first_cyc = -1;
        stab_err = 0; busy_err = 0; post_valid = 0; timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && (idx_o !== h_idx || addr_o !== h_addr || last_o !== h_last || valid_o !== 1'b1))
                stab_err++;
            if (busy_o !== valid_o) busy_err++;
            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && valid_o === 1'b1) post_valid++;
            start = (cyc == start_at) || (start_on_done && done_o === 1'b1);
            if (start) base_addr = 32'h9000;
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (valid_o === 1'b1 && ready) begin
                q_idx.push_back(idx_o); q_addr.push_back(addr_o); q_last.push_back(last_o);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                stalled = 1'b0;
            end else if (valid_o === 1'b1) begin
                stalled = 1'b1; h_idx = idx_o; h_addr = addr_o; h_last = last_o;
            end else begin
                stalled = 1'b0;
            end
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + 4) break;
            if (cyc >= max_cyc) begin
                timeout = 1'b1;
                break;
            end
        end
        start = 1'b0;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b0;
        range_v = '0; stride_v = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_o, busy_o, done_o, last_o} !== 4'b0 || idx_o !== '0 || addr_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b b=%b d=%b l=%b idx=%h addr=%h want all 0",
                     valid_o, busy_o, done_o, last_o, idx_o, addr_o);
        end
        rst = 1'b0;
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        @(negedge clk); start = 1'b0; ready = 1'b1;
        @(negedge clk); rst = 1'b1; ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || addr_o !== '0) begin
            failures++;
            $display("FAIL reset_midjob got valid=%b busy=%b addr=%h want 0 0 0", valid_o, busy_o, addr_o);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [AW-1:0] lit_addr[6] = '{32'h1000, 32'h1004, 32'h1010, 32'h1014, 32'h1020, 32'h1024};
        build_model({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        collect(0, -1, 1'b0, 100);
        checks++;
        if (timeout || q_addr.size() != 6) begin
            failures++;
            $display("FAIL basic_count got %0d beats (timeout=%0d) want 6", q_addr.size(), timeout);
        end
        for (int i = 0; i < q_addr.size() && i < 6; i++) begin
            checks++;
            if (q_addr[i] !== lit_addr[i] || q_addr[i] !== e_addr[i] || q_idx[i] !== e_idx[i] || q_last[i] !== e_last[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got addr=%h idx=%h last=%b want addr=%h idx=%h last=%b",
                         i, q_addr[i], q_idx[i], q_last[i], lit_addr[i], e_idx[i], e_last[i]);
            end
        end
        checks++;
        if (first_cyc != 0) begin
            failures++;
            $display("FAIL basic_latency got first beat at cycle %0d want 0", first_cyc);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_cyc + 1 || busy_err != 0) begin
            failures++;
            $display("FAIL basic_done got n_done=%0d done_cyc=%0d last_cyc=%0d busy_err=%0d want 1, last+1, 0",
                     n_done, done_cyc, last_cyc, busy_err);
        end
    endtask

    task automatic test_backpressure();
        build_model({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        collect(1, -1, 1'b0, 200);
        checks++;
        if (timeout || q_addr.size() != e_addr.size() || stab_err != 0) begin
            failures++;
            $display("FAIL bp_stream got beats=%0d stab_err=%0d timeout=%0d want beats=%0d stab_err=0",
                     q_addr.size(), stab_err, timeout, e_addr.size());
        end
        for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== e_addr[i] || q_idx[i] !== e_idx[i] || q_last[i] !== e_last[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got addr=%h idx=%h last=%b want addr=%h idx=%h last=%b",
                         i, q_addr[i], q_idx[i], q_last[i], e_addr[i], e_idx[i], e_last[i]);
            end
        end
        checks++;
        if (n_done != 1 || done_cyc != last_cyc + 1) begin
            failures++;
            $display("FAIL bp_done got n_done=%0d done_cyc=%0d last_cyc=%0d want 1 and last+1",
                     n_done, done_cyc, last_cyc);
        end
    endtask

    task automatic test_degenerate();
        start_job('0, {32'd8, 32'd8, 32'd8}, 32'h40);
        collect(0, -1, 1'b0, 50);
        checks++;
        if (timeout || q_addr.size() != 1 || q_addr[0] !== 32'h40 || q_last[0] !== 1'b1 || q_idx[0] !== '0) begin
            failures++;
            $display("FAIL degenerate got beats=%0d addr=%h last=%b want 1 beat addr=00000040 last=1",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'hx,
                     (q_last.size() > 0) ? q_last[0] : 1'bx);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_cyc + 1) begin
            failures++;
            $display("FAIL degenerate_done got n_done=%0d done_cyc=%0d want 1 at %0d", n_done, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_neg_stride();
        logic [AW-1:0] want[3] = '{32'h4, 32'h0, 32'hFFFF_FFFC};
        start_job({12'd1, 12'd1, 12'd3}, {32'd0, 32'd0, 32'hFFFF_FFFC}, 32'h4);
        collect(0, -1, 1'b0, 50);
        checks++;
        if (timeout || q_addr.size() != 3) begin
            failures++;
            $display("FAIL negstride_count got %0d beats want 3", q_addr.size());
        end
        for (int i = 0; i < q_addr.size() && i < 3; i++) begin
            checks++;
            if (q_addr[i] !== want[i]) begin
                failures++;
                $display("FAIL negstride_addr%0d got %h want %h", i, q_addr[i], want[i]);
            end
        end
    endtask

    task automatic test_clear();
        int got = 0;
        int dones = 0;
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            start = 1'b0; ready = 1'b1;
            if (valid_o === 1'b1) got++;
        end
        @(negedge clk); clear = 1'b1; ready = 1'b0;
        @(negedge clk); clear = 1'b0;
        checks++;
        if (got != 2 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_stop got beats=%0d valid=%b busy=%b want 2 0 0", got, valid_o, busy_o);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL clear_nodone got %0d done pulses want 0", dones);
        end
        build_model({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        collect(0, -1, 1'b0, 100);
        checks++;
        if (timeout || q_addr.size() != 6 || q_addr[0] !== 32'h1000 || q_addr[5] !== 32'h1024 || n_done != 1) begin
            failures++;
            $display("FAIL clear_restart got beats=%0d first=%h n_done=%0d want 6 beats from 00001000, 1 done",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'hx, n_done);
        end
    endtask

    task automatic test_ignored_start();
        build_model({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        start_job({12'd1, 12'd3, 12'd2}, {32'd0, 32'h10, 32'd4}, 32'h1000);
        collect(0, 2, 1'b1, 100);
        checks++;
        if (timeout || q_addr.size() != 6 || n_done != 1 || post_valid != 0) begin
            failures++;
            $display("FAIL ignstart_count got beats=%0d n_done=%0d post_valid=%0d want 6 1 0",
                     q_addr.size(), n_done, post_valid);
        end
        for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== e_addr[i] || q_idx[i] !== e_idx[i]) begin
                failures++;
                $display("FAIL ignstart_beat%0d got addr=%h idx=%h want addr=%h idx=%h",
                         i, q_addr[i], q_idx[i], e_addr[i], e_idx[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            logic [NL*CW-1:0] r;
            logic [NL*AW-1:0] s;
            logic [AW-1:0] b;
            for (int k = 0; k < NL; k++) begin
                r[k*CW +: CW] = CW'($urandom_range(0, 3));
                s[k*AW +: AW] = $urandom;
            end
            b = $urandom;
            build_model(r, s, b);
            start_job(r, s, b);
            collect(2, -1, 1'b0, 400);
            checks++;
            if (timeout || q_addr.size() != e_addr.size() || stab_err != 0 || n_done != 1 || done_cyc != last_cyc + 1) begin
                failures++;
                $display("FAIL rand%0d_stream got beats=%0d stab_err=%0d n_done=%0d timeout=%0d want beats=%0d",
                         j, q_addr.size(), stab_err, n_done, timeout, e_addr.size());
            end
            for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
                checks++;
                if (q_addr[i] !== e_addr[i] || q_idx[i] !== e_idx[i] || q_last[i] !== e_last[i]) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got addr=%h idx=%h last=%b want addr=%h idx=%h last=%b",
                             j, i, q_addr[i], q_idx[i], q_last[i], e_addr[i], e_idx[i], e_last[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_degenerate();
        test_neg_stride();
        test_clear();
        test_ignored_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
